// File: rtl/conf_pkg.sv
// Shared definitions for the shadowed configuration register file:
// default geometry, well-known register indices and the commit FSM states.
package conf_pkg;

  localparam int CONF_DATA_W   = 32;
  localparam int CONF_NUM_REGS = 32;
  localparam int CONF_ADDR_W   = 32;

  // Register indices consumed by the datapath
  localparam int IDX_MEMORY_POINTER_FC        = 0;
  localparam int IDX_FIRST_INDEX_FC_LOG       = 1;
  localparam int IDX_EXECUTION_FRAME_BY_FRAME = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_COPY = 2'd2
  } commit_state_e;

endpackage

// File: rtl/conf_commit_fsm.sv
// Commit sequencer: holds a shadow->active copy request until the engine is
// idle, then issues a single-cycle copy enable. All outputs are registered.
module conf_commit_fsm
  import conf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_commit_req,
  input  logic i_engine_busy,
  output logic o_copy_en,
  output logic o_commit_pending,
  output logic o_commit_done
);

  commit_state_e r_state;
  logic          r_copy_en;
  logic          r_commit_pending;
  logic          r_commit_done;

  // State transitions and registered outputs; requests in WAIT/COPY are absorbed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_copy_en        <= 1'b0;
      r_commit_pending <= 1'b0;
      r_commit_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_commit_done <= 1'b0;
          if (i_commit_req && i_engine_busy) begin
            r_state          <= ST_WAIT;
            r_copy_en        <= 1'b0;
            r_commit_pending <= 1'b1;
          end else if (i_commit_req) begin
            r_state          <= ST_COPY;
            r_copy_en        <= 1'b1;
            r_commit_pending <= 1'b0;
          end else begin
            r_state          <= ST_IDLE;
            r_copy_en        <= 1'b0;
            r_commit_pending <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_commit_done <= 1'b0;
          if (!i_engine_busy) begin
            r_state          <= ST_COPY;
            r_copy_en        <= 1'b1;
            r_commit_pending <= 1'b0;
          end else begin
            r_state          <= ST_WAIT;
            r_copy_en        <= 1'b0;
            r_commit_pending <= 1'b1;
          end
        end
        ST_COPY: begin
          // Active bank loads on this edge, so done rises with the new values
          r_state          <= ST_IDLE;
          r_copy_en        <= 1'b0;
          r_commit_pending <= 1'b0;
          r_commit_done    <= 1'b1;
        end
        default: begin
          r_state          <= ST_IDLE;
          r_copy_en        <= 1'b0;
          r_commit_pending <= 1'b0;
          r_commit_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_copy_en        = r_copy_en;
  assign o_commit_pending = r_commit_pending;
  assign o_commit_done    = r_commit_done;

endmodule

// File: rtl/conf_regfile_shadowed.sv
// Shadowed configuration register file: host writes land in a shadow bank,
// a commit copies the whole shadow bank into the active bank while the
// engine is idle. Provides read-back of either bank, range checking and
// dirty/pending status.
module conf_regfile_shadowed
  import conf_pkg::*;
#(
  parameter  int DATA_W   = CONF_DATA_W,
  parameter  int NUM_REGS = CONF_NUM_REGS,
  parameter  int ADDR_W   = CONF_ADDR_W,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_ext,
  input  logic [ADDR_W-1:0]          wr_addr_ext,
  input  logic [DATA_W-1:0]          wr_data_ext,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       rd_bank,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       commit_req,
  input  logic                       engine_busy,
  output logic                       commit_pending,
  output logic                       commit_done,
  output logic                       dirty,
  output logic                       addr_err,
  input  logic                       err_clr,
  output logic [NUM_REGS*DATA_W-1:0] active_regs
);

  // Range limit at full address width so high address bits cannot alias
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] r_shadow [NUM_REGS];
  logic [DATA_W-1:0] r_active [NUM_REGS];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_dirty;
  logic              r_addr_err;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_wr_hit;
  logic              w_err_new;
  logic              w_copy_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_word;

  assign w_wr_ok   = (wr_addr_ext < NUM_REGS_A);
  assign w_rd_ok   = (rd_addr < NUM_REGS_A);
  assign w_wr_hit  = wr_en_ext & w_wr_ok;
  assign w_err_new = (wr_en_ext & ~w_wr_ok) | (rd_en & ~w_rd_ok);
  assign w_wr_idx  = wr_addr_ext[IDX_W-1:0];
  assign w_rd_idx  = rd_addr[IDX_W-1:0];

  conf_commit_fsm u_commit_fsm (
    .clk              (clk),
    .reset            (reset),
    .i_commit_req     (commit_req),
    .i_engine_busy    (engine_busy),
    .o_copy_en        (w_copy_en),
    .o_commit_pending (commit_pending),
    .o_commit_done    (commit_done)
  );

  // Shadow bank: host writes, out-of-range writes are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_hit) begin
      r_shadow[w_wr_idx] <= wr_data_ext;
    end
  end

  // Active bank: whole-bank copy from the pre-edge shadow contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= {DATA_W{1'b0}};
      end
    end else if (w_copy_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= r_shadow[i];
      end
    end
  end

  // Dirty: a write always wins, so a write in the copy cycle keeps it set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dirty <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty <= 1'b1;
    end else if (w_copy_en) begin
      r_dirty <= 1'b0;
    end
  end

  // Read-back source selection; out-of-range reads return zero
  always_comb begin
    w_rd_word = {DATA_W{1'b0}};
    if (!w_rd_ok) begin
      w_rd_word = {DATA_W{1'b0}};
    end else if (rd_bank) begin
      w_rd_word = r_active[w_rd_idx];
    end else begin
      w_rd_word = r_shadow[w_rd_idx];
    end
  end

  // Registered read-back; data holds when no read is requested
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= {DATA_W{1'b0}};
      r_rd_valid <= 1'b0;
    end else if (rd_en) begin
      r_rd_data  <= w_rd_word;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  // Sticky address error; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_err <= 1'b0;
    end else if (w_err_new) begin
      r_addr_err <= 1'b1;
    end else if (err_clr) begin
      r_addr_err <= 1'b0;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign dirty    = r_dirty;
  assign addr_err = r_addr_err;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign active_regs[g*DATA_W +: DATA_W] = r_active[g];
  end

endmodule

// File: tb/tb_conf_regfile_shadowed.sv
// Directed, table-driven bench for conf_regfile_shadowed with hand-written
// sequences for the commit-timing and reset corner cases.
module tb_conf_regfile_shadowed;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 32;

  logic              clk;
  logic              reset;
  logic              wr_en_ext;
  logic [AW-1:0]     wr_addr_ext;
  logic [DW-1:0]     wr_data_ext;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_bank;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              commit_req;
  logic              engine_busy;
  logic              commit_pending;
  logic              commit_done;
  logic              dirty;
  logic              addr_err;
  logic              err_clr;
  logic [NR*DW-1:0]  active_regs;

  int n_cmp;
  int n_miss;

  conf_regfile_shadowed #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en_ext      (wr_en_ext),
    .wr_addr_ext    (wr_addr_ext),
    .wr_data_ext    (wr_data_ext),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_bank        (rd_bank),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .commit_req     (commit_req),
    .engine_busy    (engine_busy),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .dirty          (dirty),
    .addr_err       (addr_err),
    .err_clr        (err_clr),
    .active_regs    (active_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        re;
    logic [31:0] ra;
    logic        rb;
    logic        cr;
    logic        busy;
    logic        ec;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_dirty;
    logic        e_err;
    logic        e_pend;
    logic        e_done;
    logic [31:0] e_a0;
    logic [31:0] e_a2;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic re, input logic [31:0] ra, input logic rb,
                              input logic cr, input logic busy, input logic ec,
                              input logic e_rv, input logic [31:0] e_rd, input logic e_dirty,
                              input logic e_err, input logic e_pend, input logic e_done,
                              input logic [31:0] e_a0, input logic [31:0] e_a2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.rb = rb;
    v.cr = cr; v.busy = busy; v.ec = ec; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_dirty = e_dirty; v.e_err = e_err; v.e_pend = e_pend; v.e_done = e_done;
    v.e_a0 = e_a0; v.e_a2 = e_a2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en_ext = 1'b0; wr_addr_ext = 32'd0; wr_data_ext = 32'd0;
    rd_en = 1'b0; rd_addr = 32'd0; rd_bank = 1'b0;
    commit_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    wr_en_ext = v.we; wr_addr_ext = v.wa; wr_data_ext = v.wd;
    rd_en = v.re; rd_addr = v.ra; rd_bank = v.rb;
    commit_req = v.cr; engine_busy = v.busy; err_clr = v.ec;
  endtask

  function automatic logic [31:0] areg(input int idx);
    return active_regs[idx*DW +: DW];
  endfunction

  initial begin
    n_cmp  = 0;
    n_miss = 0;
    reset  = 1'b0;
    engine_busy = 1'b0;
    idle_inputs();

    //                 we    wa            wd            re    ra            rb    cr    busy  ec    rv    rd            dirty err   pend  done  a0            a2
    vt[0]  = mk(1'b1, 32'd0,        32'hDEADBEEF, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0);
    vt[1]  = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0);
    vt[2]  = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0);
    vt[3]  = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0);
    vt[4]  = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'd0);
    vt[5]  = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0);
    vt[6]  = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0);
    vt[7]  = mk(1'b1, 32'd2,        32'd5,        1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0);
    vt[8]  = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0);
    vt[9]  = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0);
    vt[10] = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0);
    vt[11] = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0);
    vt[12] = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'd5);
    vt[13] = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[14] = mk(1'b1, 32'd32,       32'h0000FFFF, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[15] = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[16] = mk(1'b1, 32'h80000000, 32'h00001234, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[17] = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[18] = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'h00000040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[19] = mk(1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[20] = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'd2,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[21] = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'd31,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[22] = mk(1'b1, 32'd31,       32'h000000A5, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);
    vt[23] = mk(1'b0, 32'd0,        32'd0,        1'b1, 32'd31,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000000A5, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd5);

    // Reset state
    #12;
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_pending", {31'd0, commit_pending}, 32'd0);
    chk("rst_done", {31'd0, commit_done}, 32'd0);
    chk("rst_dirty", {31'd0, dirty}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_active_zero", {31'd0, (active_regs == {NR*DW{1'b0}})}, 32'd1);
    #8;
    reset = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 24; i++) begin
      drive(vt[i]);
      tick();
      chk($sformatf("v%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vt[i].e_rv});
      if (vt[i].e_rv) chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].e_rd);
      chk($sformatf("v%0d_dirty", i), {31'd0, dirty}, {31'd0, vt[i].e_dirty});
      chk($sformatf("v%0d_addr_err", i), {31'd0, addr_err}, {31'd0, vt[i].e_err});
      chk($sformatf("v%0d_pending", i), {31'd0, commit_pending}, {31'd0, vt[i].e_pend});
      chk($sformatf("v%0d_done", i), {31'd0, commit_done}, {31'd0, vt[i].e_done});
      chk($sformatf("v%0d_active0", i), areg(0), vt[i].e_a0);
      chk($sformatf("v%0d_active2", i), areg(2), vt[i].e_a2);
    end
    idle_inputs();
    engine_busy = 1'b0;

    // Write in the COPY cycle: copy takes old shadow, write lands in shadow
    wr_en_ext = 1'b1; wr_addr_ext = 32'd1; wr_data_ext = 32'h22;
    tick();
    idle_inputs(); commit_req = 1'b1;
    tick();
    idle_inputs(); commit_req = 1'b1;
    wr_en_ext = 1'b1; wr_addr_ext = 32'd1; wr_data_ext = 32'h11;
    tick();
    chk("copyw_active1", areg(1), 32'h22);
    chk("copyw_active31", areg(31), 32'hA5);
    chk("copyw_done", {31'd0, commit_done}, 32'd1);
    chk("copyw_dirty", {31'd0, dirty}, 32'd1);
    idle_inputs(); rd_en = 1'b1; rd_addr = 32'd1; rd_bank = 1'b0;
    tick();
    chk("copyw_done_clr", {31'd0, commit_done}, 32'd0);
    chk("copyw_no_pend", {31'd0, commit_pending}, 32'd0);
    chk("copyw_shadow1", rd_data, 32'h11);
    rd_bank = 1'b1;
    tick();
    chk("copyw_rd_active1", rd_data, 32'h22);
    chk("copyw_active1_hold", areg(1), 32'h22);

    // Held off by a busy engine for ten cycles
    idle_inputs(); engine_busy = 1'b1;
    wr_en_ext = 1'b1; wr_addr_ext = 32'd2; wr_data_ext = 32'd9;
    tick();
    idle_inputs(); commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("wait%0d_pend", c), {31'd0, commit_pending}, 32'd1);
      chk($sformatf("wait%0d_active2", c), areg(2), 32'd5);
      chk($sformatf("wait%0d_done", c), {31'd0, commit_done}, 32'd0);
      tick();
    end
    engine_busy = 1'b0;
    tick();
    chk("wait_copy_pend", {31'd0, commit_pending}, 32'd0);
    chk("wait_copy_active2_old", areg(2), 32'd5);
    tick();
    chk("wait_done", {31'd0, commit_done}, 32'd1);
    chk("wait_active2_new", areg(2), 32'd9);
    chk("wait_dirty", {31'd0, dirty}, 32'd0);

    // Reset asserted while in WAIT
    wr_en_ext = 1'b1; wr_addr_ext = 32'd0; wr_data_ext = 32'd7;
    tick();
    idle_inputs(); commit_req = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_active0", areg(0), 32'd7);
    rd_en = 1'b1; rd_addr = 32'd0;
    tick();
    idle_inputs(); engine_busy = 1'b1; commit_req = 1'b1;
    tick();
    chk("pre_rst_pend", {31'd0, commit_pending}, 32'd1);
    chk("pre_rst_rd_data", rd_data, 32'd7);
    commit_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_active_zero", {31'd0, (active_regs == {NR*DW{1'b0}})}, 32'd1);
    chk("arst_pend", {31'd0, commit_pending}, 32'd0);
    chk("arst_rd_data", rd_data, 32'd0);
    chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("arst_dirty", {31'd0, dirty}, 32'd0);
    engine_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_rst%0d_done", c), {31'd0, commit_done}, 32'd0);
      chk($sformatf("post_rst%0d_pend", c), {31'd0, commit_pending}, 32'd0);
      chk($sformatf("post_rst%0d_active0", c), areg(0), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
